// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: WIDTH-bit add/sub as STAGES registered ripple segments.
// Define PIPELINED_RIPPLE_ADDER_OVF_EN to add the registered signed-overflow port.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module pipelined_ripple_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] go;
  logic [STAGES-1:0] mv;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] cy;
  logic [STAGES-1:0] seg_c;
  logic [WIDTH-1:0]  dat [STAGES];
  logic [WIDTH-1:0]  opb [STAGES];
  logic [SEG-1:0]    seg_s [STAGES];
  logic [WIDTH-1:0]  bx;

  assign bx = in2 ^ {WIDTH{sub}};

  // go[k]: stage k is free to take new data this cycle
  always_comb begin
    logic nxt;
    nxt = out_ready;
    go  = '0;
    mv  = '0;
    ld  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      mv[k] = vld[k] && nxt;
      go[k] = !vld[k] || mv[k];
      nxt   = go[k];
    end
    ld[0] = in_valid && rst_n && go[0];
    for (int k = 1; k < STAGES; k++) begin
      ld[k] = mv[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    logic [SEG-1:0] a;
    logic [SEG-1:0] b;
    logic [SEG-1:0] s;
    logic [SEG:0]   c;
    if (k == 0) begin : g_first
      assign a    = in1[SEG-1:0];
      assign b    = bx[SEG-1:0];
      assign c[0] = cin ^ sub;
    end else begin : g_next
      assign a    = dat[k-1][SEG*k +: SEG];
      assign b    = opb[k-1][SEG*k +: SEG];
      assign c[0] = cy[k-1];
    end
    for (genvar i = 0; i < SEG; i++) begin : g_bit
      full_adder u_fa (
        .a  (a[i]),
        .b  (b[i]),
        .ci (c[i]),
        .s  (s[i]),
        .co (c[i+1])
      );
    end
    assign seg_s[k] = s;
    assign seg_c[k] = c[SEG];
  end

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  logic msb_c;
  logic ovf_q;
  assign msb_c = g_seg[LAST].c[SEG-1];
  assign ovf   = ovf_q;
`endif

  // consumed operand-A bits are overwritten in place by sum bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      cy  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dat[k] <= '0;
        opb[k] <= '0;
      end
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) vld[k] <= 1'b1;
        else if (mv[k]) vld[k] <= 1'b0;
      end
      if (ld[0]) begin
        dat[0]          <= in1;
        dat[0][SEG-1:0] <= seg_s[0];
        opb[0]          <= bx;
        cy[0]           <= seg_c[0];
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ld[k]) begin
          dat[k]               <= dat[k-1];
          dat[k][SEG*k +: SEG] <= seg_s[k];
          opb[k]               <= opb[k-1];
          cy[k]                <= seg_c[k];
        end
      end
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
      if (ld[LAST]) ovf_q <= msb_c ^ seg_c[LAST];
`endif
    end
  end

  assign in_ready  = rst_n && go[0];
  assign out_valid = vld[LAST];
  assign sum       = dat[LAST];
  assign cout      = cy[LAST];

endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
- Parametrised, pipelined successor to the fixed 8-bit ripple-carry adder; built from the team's existing full_adder cells.
- Splits a WIDTH-bit add/subtract into STAGES ripple segments with a registered carry between segments.
- Valid/ready handshake on input and output; per-stage bubble collapsing.
- Datapath building block for the multiplier final-adder and accumulator paths.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline segments (1..WIDTH); each segment is SEG = WIDTH/STAGES bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands this cycle
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- cin  input  1  carry in
- sub  input  1  1 = subtract mode
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB

Interface:
- One clock; reset is synchronous and active-low.

Behaviour:
- Operation: B' = in2 XOR {WIDTH{sub}}, C0 = cin XOR sub; result {cout,sum} = in1 + B' + C0.
  - sub=1, cin=0 gives in1 - in2; cout=1 means no borrow.
  - Arithmetic is modulo 2^WIDTH with the carry exposed on cout.
- Stage k (k = 0..STAGES-1) holds a valid bit, the partial sum bits [SEG*(k+1)-1:0], the upper operand bits not yet consumed, and the carry out of its segment.
- Stage 0 computes segment 0 from the inputs and C0 on the accepting edge. Stage k computes segment k from stage k-1's operands and carry.
- Segment math is a chain of SEG full_adder cells. No lookahead.
- Latency: an operand accepted on edge t gives out_valid=1 with the result in the cycle after edge t+STAGES-1, i.e. STAGES cycles.
- Throughput: one operation per cycle when out_ready is held at 1.
- Stage advance:
  - Stage k loads from stage k-1 when stage k is empty or stage k's contents move on in the same cycle.
  - The last stage moves on when out_valid && out_ready.
- in_ready = !valid[0] || (stage 0 advances this cycle). in_ready is combinational from out_ready through the advance chain.
- A transfer occurs only when in_valid && in_ready. in1, in2, cin and sub are ignored otherwise.
- Bubbles collapse: an empty stage is always filled by upstream data, even while downstream is stalled.
- Full pipeline with out_ready=0:
  - in_ready=0 and all stages hold.
  - sum and cout stay stable while out_valid=1 and out_ready=0.
- Simultaneous accept and emit on a full pipeline: both occur in the same cycle; no loss or duplication.
- Ordering: results leave in acceptance order.
- Reset (rst_n=0 at a rising edge):
  - All valid bits clear.
  - out_valid=0, sum=0, cout=0.
  - in_ready=0 during reset; in_ready=1 in the first cycle after reset is released.
  - Operations in flight are discarded with no partial output.
- STAGES=1: single registered ripple adder; latency 1.

Optional Feature:
- Macro: PIPELINED_RIPPLE_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit): two's-complement signed overflow, i.e. carry into the MSB XOR carry out of the MSB.
  - ovf is registered in the last stage and aligned with sum.
  - Reset value 0. Held stable under stall like sum.
- When undefined: no ovf port and no associated logic. All other behaviour is identical.

Test Plan:
- WIDTH=32, STAGES=4, out_ready=1: in1=0xFFFFFFFF, in2=0x00000001, cin=0, sub=0 → after 4 cycles sum=0x00000000, cout=1 (carry crosses every segment).
- Subtract: in1=5, in2=7, sub=1, cin=0 → sum=0xFFFFFFFE, cout=0. With OVF_EN, in1=0x80000000, in2=1, sub=1 → sum=0x7FFFFFFF, ovf=1.
- Back-to-back: 100 random operations streamed with in_valid=1 and out_ready=1 → in_ready stays 1, results match the model in order, one per cycle after 4 cycles of latency.
- Backpressure: hold out_ready=0 while streaming → exactly 4 accepted, then in_ready=0, sum held stable. Release out_ready → all 4 drain in order and no data is lost.
- Bubble collapse: send operations A and C with a gap, out_ready=0 → A and C occupy adjacent stages; in_ready stays 1 until 4 operations are held.
- Reset mid-operation: 3 operations in flight, pulse rst_n=0 for one edge → out_valid=0, sum=0, cout=0, and no stale result after release. Also run with STAGES=1 and STAGES=32 for the edge parameter values.
